// File: rtl/ula_seq.sv
// Sequential signed ALU: single-cycle logic/arith/compare ops plus iterative
// shift-add MULT and restoring DIV, with start/done handshake and flags.
module ula_seq #(
  parameter int WIDTH = 28,
  parameter int OPW   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             startULA,
  input  logic [OPW-1:0]   selectULA,
  input  logic [WIDTH-1:0] aULA,
  input  logic [WIDTH-1:0] bULA,
  output logic [WIDTH-1:0] outputULA,
  output logic             statusULA,
  output logic             overflowULA,
  output logic             errorULA,
  output logic             busyULA,
  output logic             doneULA,
  output logic [1:0]       fsm_state_o
);

  // Handshake: a request is taken on a rising edge with startULA=1 and
  // busyULA=0; doneULA pulses for one cycle when the result registers update.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
  localparam logic [OPW-1:0] OP_COMP  = OPW'(2);
  localparam logic [OPW-1:0] OP_IGUAL = OPW'(3);
  localparam logic [OPW-1:0] OP_MAIOR = OPW'(4);
  localparam logic [OPW-1:0] OP_MENOR = OPW'(5);
  localparam logic [OPW-1:0] OP_AND   = OPW'(6);
  localparam logic [OPW-1:0] OP_OR    = OPW'(7);
  localparam logic [OPW-1:0] OP_MULT  = OPW'(8);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(9);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             status_q, status_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  // Single-cycle datapath
  logic [WIDTH-1:0] sum, diff, negb, mag_a, mag_b;
  logic             a_msb, b_msb;
  logic [WIDTH-1:0] r_out;
  logic             r_status, r_ovf, r_err;

  assign a_msb = aULA[WIDTH-1];
  assign b_msb = bULA[WIDTH-1];
  assign sum   = aULA + bULA;
  assign diff  = bULA - aULA;
  assign negb  = -bULA;
  assign mag_a = a_msb ? -aULA : aULA;
  assign mag_b = b_msb ? -bULA : bULA;

  always_comb begin
    r_out    = '0;
    r_status = 1'b0;
    r_ovf    = 1'b0;
    r_err    = 1'b0;
    case (selectULA)
      OP_ADD: begin
        r_out = sum;
        r_ovf = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        r_out = diff;
        r_ovf = (b_msb != a_msb) && (diff[WIDTH-1] != b_msb);
      end
      OP_COMP: begin
        r_out = negb;
        r_ovf = (bULA == MIN_VAL);
      end
      OP_IGUAL: r_status = (aULA == bULA);
      OP_MAIOR: begin
        r_status = ($signed(aULA) > $signed(bULA));
        r_out    = r_status ? aULA : bULA;
      end
      OP_MENOR: begin
        r_status = ($signed(aULA) < $signed(bULA));
        r_out    = r_status ? aULA : bULA;
      end
      OP_AND:  r_out = aULA & bULA;
      OP_OR:   r_out = aULA | bULA;
      OP_MULT: r_out = '0;
      // Only reaches here as a single-cycle op when the divisor is zero
      OP_DIV: begin
        r_out = '1;
        r_err = 1'b1;
      end
      default: r_err = 1'b1;
    endcase
  end

  // Iteration step; p_q holds {hi/remainder (WIDTH+1), lo/quotient (WIDTH)}
  logic [WIDTH:0]   add_hi, r_sh, trial;
  logic [PW-1:0]    mul_step, div_step, p_step;

  assign add_hi   = p_q[PW-1:WIDTH] + (p_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
  assign mul_step = {1'b0, add_hi, p_q[WIDTH-1:1]};
  assign r_sh     = {p_q[PW-2:WIDTH], p_q[WIDTH-1]};
  assign trial    = r_sh - {1'b0, mag_q};
  assign div_step = trial[WIDTH] ? {r_sh, p_q[WIDTH-2:0], 1'b0}
                                 : {trial, p_q[WIDTH-2:0], 1'b1};
  assign p_step   = is_div_q ? div_step : mul_step;

  // Sign correction applied on the final step
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo, quo_s;
  logic               mul_ovf, div_ovf;

  assign prod_s  = neg_q ? -p_step[2*WIDTH-1:0] : p_step[2*WIDTH-1:0];
  assign mul_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
  assign quo     = p_step[WIDTH-1:0];
  assign quo_s   = neg_q ? -quo : quo;
  assign div_ovf = !neg_q && quo[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    mag_d    = mag_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    out_d    = out_q;
    status_d = status_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (startULA) begin
          if ((selectULA == OP_MULT) || ((selectULA == OP_DIV) && (aULA != '0))) begin
            is_div_d = (selectULA == OP_DIV);
            neg_d    = a_msb ^ b_msb;
            mag_d    = mag_a;
            p_d      = {{(WIDTH+1){1'b0}}, mag_b};
            cnt_d    = CW'(WIDTH);
            state_d  = S_ITER;
          end else begin
            out_d    = r_out;
            status_d = r_status;
            ovf_d    = r_ovf;
            err_d    = r_err;
            done_d   = 1'b1;
          end
        end
      end
      S_ITER: begin
        p_d   = p_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(2)) state_d = S_FIN;
      end
      S_FIN: begin
        // Last of the WIDTH steps happens here, merged with sign correction
        p_d      = p_step;
        cnt_d    = '0;
        out_d    = is_div_q ? quo_s : prod_s[WIDTH-1:0];
        ovf_d    = is_div_q ? div_ovf : mul_ovf;
        status_d = 1'b0;
        err_d    = 1'b0;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      mag_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      out_q    <= '0;
      status_q <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      mag_q    <= mag_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      out_q    <= out_d;
      status_q <= status_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign outputULA   = out_q;
  assign statusULA   = status_q;
  assign overflowULA = ovf_q;
  assign errorULA    = err_q;
  assign busyULA     = (state_q != S_IDLE);
  assign doneULA     = done_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq: single-cycle ops, MULT/DIV latency, flags,
// ignored start while busy, mid-operation reset.
module tb_ula_seq;
  localparam int W = 28;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         startULA = 1'b0;
  logic [3:0]   selectULA = '0;
  logic [W-1:0] aULA = '0;
  logic [W-1:0] bULA = '0;
  logic [W-1:0] outputULA;
  logic         statusULA, overflowULA, errorULA, busyULA, doneULA;
  logic [1:0]   fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int lat, busy_n, k;

  ula_seq #(.WIDTH(W), .OPW(4)) dut (
    .clock(clock), .reset(reset), .startULA(startULA), .selectULA(selectULA),
    .aULA(aULA), .bULA(bULA), .outputULA(outputULA), .statusULA(statusULA),
    .overflowULA(overflowULA), .errorULA(errorULA), .busyULA(busyULA),
    .doneULA(doneULA), .fsm_state_o(fsm_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    selectULA = op; aULA = a; bULA = b; startULA = 1'b1;
    @(posedge clock);
    #1 startULA = 1'b0;
  endtask

  // Counts cycles after the accepting edge until doneULA; optionally pokes a
  // second request at cycle poke_at.
  task automatic wait_done(input int poke_at, output int l, output int bn);
    l = 0; bn = 0;
    while (1) begin
      @(negedge clock);
      l++;
      if (l == poke_at) begin
        startULA = 1'b1; selectULA = 4'd0; aULA = 28'd100; bULA = 28'd100;
      end else begin
        startULA = 1'b0;
      end
      if (doneULA) break;
      if (busyULA) bn++;
      if (l >= 200) break;
    end
    startULA = 1'b0;
  endtask

  task automatic flags(input string tag, input logic st, input logic ov, input logic er);
    check({tag, "_status"}, {27'd0, statusULA}, {27'd0, st});
    check({tag, "_ovf"}, {27'd0, overflowULA}, {27'd0, ov});
    check({tag, "_err"}, {27'd0, errorULA}, {27'd0, er});
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out", outputULA, '0);
    flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst_busy", {27'd0, busyULA}, '0);
    check("rst_done", {27'd0, doneULA}, '0);
    reset = 1'b0;

    start_op(4'd0, 28'd5, 28'd7);
    wait_done(0, lat, busy_n);
    check("add_lat", W'(lat), 28'd1);
    check("add_out", outputULA, 28'd12);
    flags("add", 1'b0, 1'b0, 1'b0);

    start_op(4'd0, 28'h7FFFFFF, 28'd1);
    wait_done(0, lat, busy_n);
    check("addov_out", outputULA, 28'h8000000);
    flags("addov", 1'b0, 1'b1, 1'b0);

    start_op(4'd1, 28'd3, 28'd10);
    wait_done(0, lat, busy_n);
    check("sub_out", outputULA, 28'd7);
    flags("sub", 1'b0, 1'b0, 1'b0);

    start_op(4'd2, 28'd0, 28'd5);
    wait_done(0, lat, busy_n);
    check("comp_out", outputULA, 28'hFFFFFFB);
    flags("comp", 1'b0, 1'b0, 1'b0);

    start_op(4'd2, 28'd0, 28'h8000000);
    wait_done(0, lat, busy_n);
    check("compmin_out", outputULA, 28'h8000000);
    flags("compmin", 1'b0, 1'b1, 1'b0);

    start_op(4'd4, 28'hFFFFFFF, 28'd2);
    wait_done(0, lat, busy_n);
    check("maior_out", outputULA, 28'd2);
    flags("maior", 1'b0, 1'b0, 1'b0);

    start_op(4'd5, 28'hFFFFFFF, 28'd2);
    wait_done(0, lat, busy_n);
    check("menor_out", outputULA, 28'hFFFFFFF);
    flags("menor", 1'b1, 1'b0, 1'b0);

    start_op(4'd3, 28'd9, 28'd9);
    wait_done(0, lat, busy_n);
    check("igual_out", outputULA, 28'd0);
    flags("igual", 1'b1, 1'b0, 1'b0);

    // MULT with an ignored start pulsed at cycle 5
    start_op(4'd8, 28'hFFFFFFA, 28'd7);
    wait_done(5, lat, busy_n);
    check("mul_lat", W'(lat), 28'd29);
    check("mul_busy", W'(busy_n), 28'd28);
    check("mul_out", outputULA, 28'hFFFFFD6);
    flags("mul", 1'b0, 1'b0, 1'b0);
    check("mul_state", {26'd0, fsm_state}, 28'd0);
    @(negedge clock);
    check("mul_done_pulse", {27'd0, doneULA}, '0);
    check("mul_hold", outputULA, 28'hFFFFFD6);

    start_op(4'd8, 28'h0004000, 28'h0004000);
    wait_done(0, lat, busy_n);
    check("mulov_out", outputULA, 28'd0);
    flags("mulov", 1'b0, 1'b1, 1'b0);

    start_op(4'd9, 28'd2, 28'hFFFFFF9);
    wait_done(0, lat, busy_n);
    check("div_lat", W'(lat), 28'd29);
    check("div_out", outputULA, 28'hFFFFFFD);
    flags("div", 1'b0, 1'b0, 1'b0);

    start_op(4'd9, 28'hFFFFFFD, 28'hFFFFFEC);
    wait_done(0, lat, busy_n);
    check("divneg_out", outputULA, 28'd6);

    start_op(4'd9, 28'hFFFFFFF, 28'h8000000);
    wait_done(0, lat, busy_n);
    check("divov_out", outputULA, 28'h8000000);
    flags("divov", 1'b0, 1'b1, 1'b0);

    start_op(4'd9, 28'd0, 28'd9);
    wait_done(0, lat, busy_n);
    check("div0_lat", W'(lat), 28'd1);
    check("div0_out", outputULA, 28'hFFFFFFF);
    flags("div0", 1'b0, 1'b0, 1'b1);

    // Reset mid-MULT aborts without a done pulse
    start_op(4'd8, 28'd3, 28'd3);
    k = 0;
    while (k < 10) begin
      @(negedge clock);
      k++;
    end
    check("pre_rst_busy", {27'd0, busyULA}, 28'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mrst_out", outputULA, '0);
    flags("mrst", 1'b0, 1'b0, 1'b0);
    check("mrst_busy", {27'd0, busyULA}, '0);
    check("mrst_done", {27'd0, doneULA}, '0);
    reset = 1'b0;
    @(negedge clock);
    check("mrst_done2", {27'd0, doneULA}, '0);

    start_op(4'd0, 28'd1, 28'd1);
    wait_done(0, lat, busy_n);
    check("add11_out", outputULA, 28'd2);

    start_op(4'd12, 28'd5, 28'd5);
    wait_done(0, lat, busy_n);
    check("ill_lat", W'(lat), 28'd1);
    check("ill_out", outputULA, 28'd0);
    flags("ill", 1'b0, 1'b0, 1'b1);

    start_op(4'd6, 28'h00000F0, 28'h000003C);
    wait_done(0, lat, busy_n);
    check("and_out", outputULA, 28'h0000030);
    flags("and", 1'b0, 1'b0, 1'b0);

    start_op(4'd7, 28'h00000F0, 28'h000003C);
    wait_done(0, lat, busy_n);
    check("or_out", outputULA, 28'h00000FC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
